mtc_sl_tx_serializer: RTL and testbench

//  Downstream of the MTC builder. Takes the n_PRIMARY_MTC parallel MTC2SL words produced each BC and

---
 rtl/mtc_sl_tx_serializer_pkg.sv | 13 +
 rtl/mtc_sl_tx_serializer_group_fifo.sv | 55 +++++
 rtl/mtc_sl_tx_serializer.sv | 121 ++++++++++++
 tb/tb_mtc_sl_tx_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mtc_sl_tx_serializer_pkg.sv
// rtl/mtc_sl_tx_serializer_pkg.sv - shared MTC2SL bus constants and group type
package mtc_sl_tx_serializer_pkg;

  localparam int MTC2SL_LEN       = 32;
  localparam int MTC2SL_VALID_BIT = MTC2SL_LEN - 1;
  localparam int N_PRIMARY_MTC    = 3;

  typedef struct packed {
    logic [N_PRIMARY_MTC-1:0]                 mask;
    logic [N_PRIMARY_MTC-1:0][MTC2SL_LEN-1:0] words;
  } mtc_group_t;

endpackage

// File: rtl/mtc_sl_tx_serializer_group_fifo.sv
// rtl/mtc_sl_tx_serializer_group_fifo.sv - single-clock group FIFO with registered full/level
module mtc_group_fifo #(
  parameter int WIDTH = 99,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;

  // Head is read combinationally so the consumer can pop and use it on the same edge.
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en)
      level_nxt = level + 1'b1;
    else if (rd_en && !wr_en)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/mtc_sl_tx_serializer.sv
// rtl/mtc_sl_tx_serializer.sv - buffers MTC candidate groups and streams valid words to the SL link
module mtc_sl_tx_serializer
  import mtc_sl_tx_serializer_pkg::*;
#(
  parameter int N_MTC      = N_PRIMARY_MTC,
  parameter int MTC_W      = MTC2SL_LEN,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic [N_MTC-1:0][MTC_W-1:0]     mtc_i,
  output logic [MTC_W-1:0]                sl_data_o,
  output logic                            sl_valid_o,
  output logic                            sl_last_o,
  input  logic                            sl_ready_i,
  output logic                            fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic [DROP_CNT_W-1:0]           drop_cnt_o
);

  localparam int GW = N_MTC * (MTC_W + 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [N_MTC-1:0]             in_mask;
  logic [GW-1:0]                fifo_rd_data;
  logic [N_MTC-1:0]             head_mask;
  logic [N_MTC-1:0][MTC_W-1:0]  head_words;
  logic [N_MTC-1:0][MTC_W-1:0]  hold_words;
  logic [N_MTC-1:0]             rem_mask;
  logic [N_MTC-1:0]             src_mask;
  logic [N_MTC-1:0][MTC_W-1:0]  src_words;
  logic [N_MTC-1:0]             sel_oh;
  logic [N_MTC-1:0]             next_rem;
  logic [MTC_W-1:0]             sel_word;
  logic                         fifo_empty;
  logic                         accept;
  logic                         pop;
  logic                         push;
  logic                         drop;

  always_comb begin
    in_mask = '0;
    for (int k = 0; k < N_MTC; k++)
      in_mask[k] = mtc_i[k][MTC_W-1];
  end

  assign head_mask  = fifo_rd_data[GW-1 -: N_MTC];
  assign head_words = fifo_rd_data[N_MTC*MTC_W-1:0];
  assign fifo_empty = (fifo_level_o == '0);
  assign accept     = sl_valid_o & sl_ready_i;

  // A pop either starts from idle or chains straight after the last beat of a group.
  assign pop  = !fifo_empty && ((state == IDLE) || (accept && sl_last_o));
  assign push = (|in_mask) && (!fifo_full_o || pop);
  assign drop = (|in_mask) && fifo_full_o && !pop;

  mtc_group_fifo #(
    .WIDTH (GW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({in_mask, mtc_i}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full_o),
    .level   (fifo_level_o)
  );

  // Lowest set bit of the active mask picks the next word to present.
  assign src_mask  = pop ? head_mask  : rem_mask;
  assign src_words = pop ? head_words : hold_words;
  assign sel_oh    = src_mask & (~src_mask + 1'b1);
  assign next_rem  = src_mask & ~sel_oh;

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_MTC; k++)
      if (sel_oh[k])
        sel_word = src_words[k];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      sl_data_o  <= '0;
      sl_valid_o <= 1'b0;
      sl_last_o  <= 1'b0;
      hold_words <= '0;
      rem_mask   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (drop && (drop_cnt_o != {DROP_CNT_W{1'b1}}))
        drop_cnt_o <= drop_cnt_o + 1'b1;

      if (pop) begin
        hold_words <= head_words;
        rem_mask   <= next_rem;
        sl_data_o  <= sel_word;
        sl_valid_o <= 1'b1;
        sl_last_o  <= (next_rem == '0);
        state      <= SEND;
      end else if (state == SEND && accept) begin
        if (sl_last_o) begin
          sl_valid_o <= 1'b0;
          sl_last_o  <= 1'b0;
          state      <= IDLE;
        end else begin
          rem_mask  <= next_rem;
          sl_data_o <= sel_word;
          sl_last_o <= (next_rem == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mtc_sl_tx_serializer.sv
// tb/tb_mtc_sl_tx_serializer.sv - randomized bench against a queue-based serializer model
module tb_mtc_sl_tx_serializer;
  import mtc_sl_tx_serializer_pkg::*;

  localparam int N  = N_PRIMARY_MTC;
  localparam int W  = MTC2SL_LEN;
  localparam int D  = 8;
  localparam int CW = 16;

  logic                    clock;
  logic                    rst;
  logic [N-1:0][W-1:0]     mtc;
  logic [W-1:0]            sl_data;
  logic                    sl_valid;
  logic                    sl_last;
  logic                    sl_ready;
  logic                    fifo_full;
  logic [$clog2(D):0]      fifo_level;
  logic [CW-1:0]           drop_cnt;

  mtc_sl_tx_serializer #(
    .N_MTC(N), .MTC_W(W), .FIFO_DEPTH(D), .DROP_CNT_W(CW)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .mtc_i        (mtc),
    .sl_data_o    (sl_data),
    .sl_valid_o   (sl_valid),
    .sl_last_o    (sl_last),
    .sl_ready_i   (sl_ready),
    .fifo_full_o  (fifo_full),
    .fifo_level_o (fifo_level),
    .drop_cnt_o   (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: groups waiting in the FIFO, and the words still to send of the in-flight group.
  mtc_group_t  m_fifo[$];
  logic [W-1:0] m_cur[$];
  int           m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0][W-1:0] make_group(input logic [N-1:0] mask);
    logic [N-1:0][W-1:0] g;
    for (int k = 0; k < N; k++) begin
      g[k] = $urandom;
      g[k][W-1] = mask[k];
    end
    return g;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0][W-1:0] g, input logic rdy);
    logic [N-1:0] mask;
    bit           was_full;
    bit           popped;
    mtc_group_t   grp;
    if (r) begin
      m_fifo.delete();
      m_cur.delete();
      m_drop = 0;
      return;
    end
    if (m_cur.size() > 0 && rdy)
      void'(m_cur.pop_front());
    was_full = (m_fifo.size() == D);
    popped   = (m_fifo.size() > 0) && (m_cur.size() == 0);
    if (popped) begin
      grp = m_fifo.pop_front();
      for (int k = 0; k < N; k++)
        if (grp.mask[k])
          m_cur.push_back(grp.words[k]);
    end
    for (int k = 0; k < N; k++)
      mask[k] = g[k][W-1];
    if (mask != '0) begin
      if (!was_full || popped) begin
        grp.mask  = mask;
        grp.words = g;
        m_fifo.push_back(grp);
      end else if (m_drop < (1 << CW) - 1) begin
        m_drop++;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0][W-1:0] g, input logic rdy);
    rst      = r;
    mtc      = g;
    sl_ready = rdy;
    @(posedge clock);
    model_edge(r, g, rdy);
    #1;
    chk("valid", 32'(sl_valid), 32'(m_cur.size() > 0));
    if (m_cur.size() > 0) begin
      chk("data", sl_data, m_cur[0]);
      chk("last", 32'(sl_last), 32'(m_cur.size() == 1));
    end else begin
      chk("last_idle", 32'(sl_last), 32'd0);
    end
    chk("level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("full", 32'(fifo_full), 32'(m_fifo.size() == D));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      cycle(1'b0, make_group(3'b000), rdy);
  endtask

  initial begin
    rst      = 1'b1;
    mtc      = '0;
    sl_ready = 1'b0;

    cycle(1'b1, make_group(3'b000), 1'b0);
    cycle(1'b1, make_group(3'b000), 1'b0);
    chk("rst_data", sl_data, 32'd0);
    idle(2, 1'b1);

    // Full group, continuous ready.
    cycle(1'b0, make_group(3'b111), 1'b1);
    chk("t1_no_beat_at_k", 32'(sl_valid), 32'd0);
    idle(5, 1'b1);

    // Sparse group, then empty groups that must not be written.
    cycle(1'b0, make_group(3'b101), 1'b1);
    idle(4, 1'b1);
    cycle(1'b0, make_group(3'b000), 1'b1);
    cycle(1'b0, make_group(3'b000), 1'b1);
    chk("t2_empty_level", 32'(fifo_level), 32'd0);

    // Backpressure during idx1.
    cycle(1'b0, make_group(3'b111), 1'b1);
    idle(2, 1'b1);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // Overflow with ready low, then drain.
    for (int i = 0; i < D + 3; i++)
      cycle(1'b0, make_group(3'($urandom_range(1, 7))), 1'b0);
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_level", 32'(fifo_level), 32'(D));
    idle(40, 1'b1);

    // Back-to-back groups.
    for (int i = 0; i < 6; i++)
      cycle(1'b0, make_group(3'($urandom_range(1, 7))), 1'b1);
    idle(20, 1'b1);

    // Reset mid-group with more groups queued.
    cycle(1'b0, make_group(3'b111), 1'b1);
    cycle(1'b0, make_group(3'b011), 1'b1);
    cycle(1'b0, make_group(3'b110), 1'b1);
    cycle(1'b1, make_group(3'b000), 1'b1);
    chk("t6_valid", 32'(sl_valid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    cycle(1'b0, make_group(3'b011), 1'b1);
    idle(5, 1'b1);

    // Random traffic, alternating light and heavy backpressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic rdy;
        rdy = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
        cycle(1'b0, make_group(3'($urandom_range(0, 7))), rdy);
      end
    end
    idle(60, 1'b1);
    chk("final_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
